// File: rtl/ioctl_pkg.sv
// Shared types and helpers for the HPS ioctl download router.
package ioctl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE
   } ioctl_state_t;

   localparam int unsigned IDX_ROM = 0;
   localparam int unsigned IDX_MOD = 1;
   localparam int unsigned IDX_DIP = 254;

   localparam int unsigned MAX_REGIONS = 8;
   localparam int unsigned MAX_AW      = 32;
   localparam int unsigned VEC_W       = MAX_REGIONS * MAX_AW;

   // Extract slice i of width w from a packed per-region parameter vector.
   function automatic logic [MAX_AW-1:0] region_slice(input logic [VEC_W-1:0] vec,
                                                      input int unsigned      i,
                                                      input int unsigned      w);
      return MAX_AW'(vec >> (i * w));
   endfunction

endpackage

// File: rtl/ioctl_region_match.sv
// Combinational address-window match; the lowest-indexed matching region wins.
module ioctl_region_match
   import ioctl_pkg::*;
#(
   parameter int unsigned             REGIONS     = 4,
   parameter int unsigned             AW          = 25,
   parameter int unsigned             RAW         = 16,
   parameter logic [REGIONS*AW-1:0]   REGION_BASE = '0,
   parameter logic [REGIONS*AW-1:0]   REGION_SIZE = '0
) (
   input  logic [AW-1:0]      addr_i,
   output logic [REGIONS-1:0] match_c,
   output logic [RAW-1:0]     offset_c,
   output logic               hit_c
);

   logic [REGIONS-1:0] in_win;
   logic [RAW-1:0]     off_all [REGIONS];

   // Window test by subtraction: no borrow from base, borrow against size.
   for (genvar g = 0; g < int'(REGIONS); g++) begin : g_win
      localparam logic [AW-1:0] BASE = AW'(region_slice(VEC_W'(REGION_BASE), g, AW));
      localparam logic [AW-1:0] SIZE = AW'(region_slice(VEC_W'(REGION_SIZE), g, AW));

      logic [AW:0] rel;
      logic        below_size;

      assign rel        = {1'b0, addr_i} - {1'b0, BASE};
      assign below_size = 1'(({1'b0, rel[AW-1:0]} - {1'b0, SIZE}) >> AW);
      assign in_win[g]  = ~rel[AW] & below_size;
      assign off_all[g] = rel[RAW-1:0];
   end

   always_comb begin
      match_c  = '0;
      offset_c = '0;
      for (int i = int'(REGIONS) - 1; i >= 0; i--) begin
         if (in_win[i]) begin
            match_c    = '0;
            match_c[i] = 1'b1;
            offset_c   = off_all[i];
         end
      end
   end

   assign hit_c = |in_win;

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the hps_io ioctl byte stream to ROM regions, captures DIP/mod bytes,
// and reports per-region fill and overall load completion status.
module ioctl_rom_router
   import ioctl_pkg::*;
#(
   parameter int unsigned             REGIONS     = 4,
   parameter int unsigned             AW          = 25,
   parameter int unsigned             RAW         = 16,
   parameter logic [REGIONS*AW-1:0]   REGION_BASE = '0,
   parameter logic [REGIONS*AW-1:0]   REGION_SIZE = '0,
   parameter int unsigned             ROM_INDEX   = IDX_ROM,
   parameter int unsigned             MOD_INDEX   = IDX_MOD,
   parameter int unsigned             DIP_INDEX   = IDX_DIP,
   parameter int unsigned             DIP_BYTES   = 8
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   ioctl_download,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [AW-1:0]          ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic [REGIONS-1:0]     rom_wr,
   output logic [RAW-1:0]         rom_addr,
   output logic [7:0]             rom_data,
   output logic [8*DIP_BYTES-1:0] dip,
   output logic [7:0]             mod,
   output logic [REGIONS-1:0]     region_full,
   output logic                   busy,
   output logic                   load_done,
   output logic                   load_error
);

   ioctl_state_t           state_q;
   logic                   dl_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;
   logic [REGIONS-1:0]     rom_wr_q;
   logic [RAW-1:0]         rom_addr_q;
   logic [7:0]             rom_data_q;
   logic [8*DIP_BYTES-1:0] dip_q;
   logic [7:0]             mod_q;
   logic [REGIONS-1:0]     full_vec;
   logic [REGIONS-1:0]     mismatch;

   logic [REGIONS-1:0]     match_c;
   logic [RAW-1:0]         offset_c;
   logic                   hit_c;
   logic                   is_rom_c;
   logic                   start_c;
   logic                   route_c;

   ioctl_region_match #(
      .REGIONS     (REGIONS),
      .AW          (AW),
      .RAW         (RAW),
      .REGION_BASE (REGION_BASE),
      .REGION_SIZE (REGION_SIZE)
   ) u_match (
      .addr_i   (ioctl_addr),
      .match_c  (match_c),
      .offset_c (offset_c),
      .hit_c    (hit_c)
   );

   // A ROM load starts only on a rising download edge carrying the ROM index.
   assign is_rom_c = (ioctl_index == 8'(ROM_INDEX));
   assign start_c  = ((state_q == IDLE) || (state_q == DONE)) &&
                     ioctl_download && !dl_q && is_rom_c;
   assign route_c  = (state_q == LOAD) && ioctl_wr && is_rom_c && hit_c;

   // Per-region saturating write counters; duplicate addresses still count.
   for (genvar g = 0; g < int'(REGIONS); g++) begin : g_cnt
      localparam logic [AW-1:0] SIZE_RAW = AW'(region_slice(VEC_W'(REGION_SIZE), g, AW));
      localparam logic [AW:0]   SIZE     = {1'b0, SIZE_RAW};

      logic [AW:0] cnt_q;
      logic [AW:0] cnt_d;
      logic        full_q;

      always_comb begin
         cnt_d = cnt_q;
         if (start_c) begin
            cnt_d = '0;
         end else if (route_c && match_c[g] && (cnt_q != SIZE)) begin
            cnt_d = cnt_q + (AW+1)'(1);
         end
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == SIZE);
         end
      end

      assign full_vec[g] = full_q;
      assign mismatch[g] = (cnt_q != SIZE);
   end

   // Load sequencing FSM with registered status outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dl_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         case (state_q)
            IDLE, DONE: begin
               if (start_c) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            LOAD: begin
               if (!ioctl_download) begin
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               err_q   <= |mismatch;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rom_wr_q   <= '0;
         rom_addr_q <= '0;
         rom_data_q <= '0;
      end else begin
         rom_wr_q <= route_c ? match_c : '0;
         if (route_c) begin
            rom_addr_q <= offset_c;
            rom_data_q <= ioctl_dout;
         end
      end
   end

   // DIP and mod capture is independent of the ROM FSM.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dip_q <= '0;
         mod_q <= '0;
      end else if (ioctl_wr) begin
         if (ioctl_index == 8'(MOD_INDEX)) begin
            mod_q <= ioctl_dout;
         end
         if (ioctl_index == 8'(DIP_INDEX)) begin
            for (int unsigned k = 0; k < DIP_BYTES; k++) begin
               if (ioctl_addr == AW'(k)) begin
                  dip_q[8*k +: 8] <= ioctl_dout;
               end
            end
         end
      end
   end

   assign rom_wr      = rom_wr_q;
   assign rom_addr    = rom_addr_q;
   assign rom_data    = rom_data_q;
   assign dip         = dip_q;
   assign mod         = mod_q;
   assign region_full = full_vec;
   assign busy        = busy_q;
   assign load_done   = done_q;
   assign load_error  = err_q;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Scoreboard bench: a 3-region router (A) and a 2-region overlapping router (B).
module tb_ioctl_rom_router;

   localparam int unsigned AW  = 25;
   localparam int unsigned RAW = 16;

   localparam logic [3*AW-1:0] A_BASE = {25'h0FF00, 25'h0E000, 25'h00000};
   localparam logic [3*AW-1:0] A_SIZE = {25'h00100, 25'h01000, 25'h08000};
   localparam logic [2*AW-1:0] B_BASE = {25'h00080, 25'h00000};
   localparam logic [2*AW-1:0] B_SIZE = {25'h00100, 25'h00100};

   logic           clk_sys = 1'b0;
   logic           reset_n = 1'b0;
   logic           dl_a    = 1'b0;
   logic           dl_b    = 1'b0;
   logic           wr      = 1'b0;
   logic [7:0]     idx     = 8'd0;
   logic [AW-1:0]  addr    = '0;
   logic [7:0]     dout    = 8'd0;

   logic [2:0]     rom_wr_a,   full_a;
   logic [RAW-1:0] rom_addr_a;
   logic [7:0]     rom_data_a, mod_a;
   logic [63:0]    dip_a;
   logic           busy_a, done_a, err_a;

   logic [1:0]     rom_wr_b,   full_b;
   logic [RAW-1:0] rom_addr_b;
   logic [7:0]     rom_data_b, mod_b;
   logic [63:0]    dip_b;
   logic           busy_b, done_b, err_b;

   always #5 clk_sys = ~clk_sys;

   ioctl_rom_router #(
      .REGIONS(3), .AW(AW), .RAW(RAW), .REGION_BASE(A_BASE), .REGION_SIZE(A_SIZE)
   ) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(dl_a), .ioctl_wr(wr),
      .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .rom_wr(rom_wr_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a), .dip(dip_a),
      .mod(mod_a), .region_full(full_a), .busy(busy_a), .load_done(done_a),
      .load_error(err_a)
   );

   ioctl_rom_router #(
      .REGIONS(2), .AW(AW), .RAW(RAW), .REGION_BASE(B_BASE), .REGION_SIZE(B_SIZE)
   ) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(dl_b), .ioctl_wr(wr),
      .ioctl_index(idx), .ioctl_addr(addr), .ioctl_dout(dout),
      .rom_wr(rom_wr_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b), .dip(dip_b),
      .mod(mod_b), .region_full(full_b), .busy(busy_b), .load_done(done_b),
      .load_error(err_b)
   );

   typedef struct packed {
      logic [7:0]  wr;
      logic [15:0] ad;
      logic [7:0]  dt;
      logic [31:0] due;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc_n = 0;
   int unsigned pa[3] = '{0, 0, 0};
   int unsigned p0[3];
   logic        a_load = 1'b0;
   logic        b_load = 1'b0;

   int unsigned ba[3] = '{32'h0000, 32'hE000, 32'hFF00};
   int unsigned sa[3] = '{32'h8000, 32'h1000, 32'h0100};
   int unsigned bb[2] = '{32'h0000, 32'h0080};
   int unsigned sb[2] = '{32'h0100, 32'h0100};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected router outputs for a ROM byte, queued with their due cycle.
   task automatic push(input logic [7:0] i_idx, input logic [AW-1:0] a, input logic [7:0] d);
      exp_t e;
      logic found;
      if (i_idx != 8'd0) return;
      if (a_load) begin
         found = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (!found && 32'(a) >= ba[i] && 32'(a) < ba[i] + sa[i]) begin
               found = 1'b1;
               e.wr  = 8'(1 << i);
               e.ad  = 16'(32'(a) - ba[i]);
               e.dt  = d;
               e.due = cyc_n + 1;
               qa.push_back(e);
            end
         end
      end
      if (b_load) begin
         found = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (!found && 32'(a) >= bb[i] && 32'(a) < bb[i] + sb[i]) begin
               found = 1'b1;
               e.wr  = 8'(1 << i);
               e.ad  = 16'(32'(a) - bb[i]);
               e.dt  = d;
               e.due = cyc_n + 1;
               qb.push_back(e);
            end
         end
      end
   endtask

   task automatic mon();
      exp_t e;
      if (qa.size() > 0 && qa[0].due == cyc_n) begin
         e = qa.pop_front();
         chk("a_rom_wr",   64'(rom_wr_a),   64'(e.wr));
         chk("a_rom_addr", 64'(rom_addr_a), 64'(e.ad));
         chk("a_rom_data", 64'(rom_data_a), 64'(e.dt));
      end else if (rom_wr_a != 3'b000) begin
         chk("a_unexpected_wr", 64'(rom_wr_a), 64'd0);
      end
      for (int i = 0; i < 3; i++) pa[i] += 32'(rom_wr_a[i]);
      if (qb.size() > 0 && qb[0].due == cyc_n) begin
         e = qb.pop_front();
         chk("b_rom_wr",   64'(rom_wr_b),   64'(e.wr));
         chk("b_rom_addr", 64'(rom_addr_b), 64'(e.ad));
         chk("b_rom_data", 64'(rom_data_b), 64'(e.dt));
      end else if (rom_wr_b != 2'b00) begin
         chk("b_unexpected_wr", 64'(rom_wr_b), 64'd0);
      end
   endtask

   task automatic half();
      @(negedge clk_sys);
      mon();
   endtask

   task automatic rise();
      @(posedge clk_sys);
      cyc_n++;
      #1;
   endtask

   task automatic cyc();
      half();
      rise();
   endtask

   task automatic put(input logic [7:0] i_idx, input logic [AW-1:0] a, input logic [7:0] d);
      idx  = i_idx;
      addr = a;
      dout = d;
      wr   = 1'b1;
      push(i_idx, a, d);
      half();
      rise();
      wr = 1'b0;
   endtask

   task automatic rom_range(input int unsigned lo, input int unsigned hi);
      for (int unsigned a = lo; a <= hi; a++) put(8'd0, AW'(a), 8'(a ^ (a >> 8)));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rom_wr"},   64'(rom_wr_a),   64'd0);
      chk({tag, "_rom_addr"}, 64'(rom_addr_a), 64'd0);
      chk({tag, "_rom_data"}, 64'(rom_data_a), 64'd0);
      chk({tag, "_dip"},      dip_a,           64'd0);
      chk({tag, "_mod"},      64'(mod_a),      64'd0);
      chk({tag, "_full"},     64'(full_a),     64'd0);
      chk({tag, "_busy"},     64'(busy_a),     64'd0);
      chk({tag, "_done"},     64'(done_a),     64'd0);
      chk({tag, "_error"},    64'(err_a),      64'd0);
      chk({tag, "_b_done"},   64'(done_b),     64'd0);
      chk({tag, "_b_full"},   64'(full_b),     64'd0);
      chk({tag, "_b_dip"},    dip_b,           64'd0);
   endtask

   initial begin
      // Reset state
      rise();
      rise();
      half();
      chk_all_zero("reset");
      rise();
      reset_n = 1'b1;
      cyc();

      // Full image into A: three windows plus dropped gap bytes
      idx  = 8'd0;
      dl_a = 1'b1;
      cyc();
      a_load = 1'b1;
      half();
      chk("a_load_busy", 64'(busy_a), 64'd1);
      chk("a_load_done", 64'(done_a), 64'd0);
      rise();
      p0 = pa;
      rom_range(32'h0000, 32'h7FFF);
      rom_range(32'h8000, 32'h80FF);
      rom_range(32'hDF00, 32'hDFFF);
      rom_range(32'hE000, 32'hFFFE);
      dl_a = 1'b0;
      put(8'd0, AW'(32'hFFFF), 8'hFF ^ 8'hFF);
      a_load = 1'b0;
      half();
      chk("a_fall_busy", 64'(busy_a), 64'd1);
      chk("a_fall_done", 64'(done_a), 64'd0);
      rise();
      half();
      chk("a_full_done",  64'(done_a), 64'd1);
      chk("a_full_error", 64'(err_a),  64'd0);
      chk("a_full_rf",    64'(full_a), 64'd7);
      chk("a_full_busy",  64'(busy_a), 64'd0);
      rise();
      chk("a_pulses_r0", 64'(pa[0] - p0[0]), 64'h8000);
      chk("a_pulses_r1", 64'(pa[1] - p0[1]), 64'h1000);
      chk("a_pulses_r2", 64'(pa[2] - p0[2]), 64'h0100);

      // Partial image ending at 0xEFFE, restarted from DONE
      dl_a = 1'b1;
      half();
      chk("a_restart_done_hold", 64'(done_a), 64'd1);
      rise();
      half();
      chk("a_restart_done_drop", 64'(done_a), 64'd0);
      chk("a_restart_busy",      64'(busy_a), 64'd1);
      chk("a_restart_rf",        64'(full_a), 64'd0);
      rise();
      a_load = 1'b1;
      rom_range(32'h0000, 32'h7FFF);
      rom_range(32'hE000, 32'hEFFD);
      dl_a = 1'b0;
      put(8'd0, AW'(32'hEFFE), 8'hEF ^ 8'hFE);
      a_load = 1'b0;
      half();
      chk("a_part_done_early", 64'(done_a), 64'd0);
      rise();
      half();
      chk("a_part_done",  64'(done_a), 64'd1);
      chk("a_part_error", 64'(err_a),  64'd1);
      chk("a_part_rf",    64'(full_a), 64'd1);
      rise();

      // DIP capture; addresses 8 and 9 are ignored, FSMs untouched
      dl_a = 1'b1;
      for (int unsigned a = 0; a < 10; a++) put(8'd254, AW'(a), 8'(32'hA0 + a));
      dl_a = 1'b0;
      half();
      chk("dip_a",      dip_a,            64'hA7A6A5A4A3A2A1A0);
      chk("dip_b",      dip_b,            64'hA7A6A5A4A3A2A1A0);
      chk("dip_a_busy", 64'(busy_a),      64'd0);
      chk("dip_a_done", 64'(done_a),      64'd1);
      chk("dip_b_busy", 64'(busy_b),      64'd0);
      chk("dip_b_done", 64'(done_b),      64'd0);
      rise();

      // Mod capture: last write wins, ROM state unchanged
      dl_a = 1'b1;
      put(8'd1, AW'(0), 8'h02);
      half();
      chk("mod_first", 64'(mod_a), 64'h02);
      rise();
      put(8'd1, AW'(1), 8'h04);
      put(8'd1, AW'(2), 8'h03);
      half();
      chk("mod_last",    64'(mod_a),  64'h03);
      chk("mod_rf",      64'(full_a), 64'd1);
      chk("mod_done",    64'(done_a), 64'd1);
      chk("mod_error",   64'(err_a),  64'd1);
      chk("mod_busy",    64'(busy_a), 64'd0);
      rise();
      dl_a = 1'b0;
      cyc();

      // Overlapping windows on B
      idx  = 8'd0;
      dl_b = 1'b1;
      cyc();
      b_load = 1'b1;
      put(8'd0, AW'(32'h090), 8'h5A);
      half();
      chk("ovl_low_wr",   64'(rom_wr_b),   64'd1);
      chk("ovl_low_addr", 64'(rom_addr_b), 64'h90);
      rise();
      put(8'd0, AW'(32'h110), 8'hC3);
      half();
      chk("ovl_high_wr",   64'(rom_wr_b),   64'd2);
      chk("ovl_high_addr", 64'(rom_addr_b), 64'h90);
      rise();
      dl_b   = 1'b0;
      b_load = 1'b0;
      cyc();
      cyc();
      half();
      chk("ovl_done",  64'(done_b), 64'd1);
      chk("ovl_error", 64'(err_b),  64'd1);
      chk("ovl_rf",    64'(full_b), 64'd0);
      rise();

      // Reset in the middle of an A load
      dl_a = 1'b1;
      cyc();
      a_load = 1'b1;
      rom_range(32'd0, 32'd99);
      a_load = 1'b0;
      cyc();
      chk("pre_reset_queue", 64'(qa.size()), 64'd0);
      reset_n = 1'b0;
      dl_a    = 1'b0;
      half();
      chk_all_zero("midreset");
      rise();
      cyc();
      reset_n = 1'b1;
      cyc();

      // Reload on B; duplicates fill region1 and saturate its counter
      dl_b = 1'b1;
      cyc();
      b_load = 1'b1;
      rom_range(32'h000, 32'h17F);
      rom_range(32'h100, 32'h17E);
      put(8'd0, AW'(32'h100), 8'h11);
      dl_b = 1'b0;
      put(8'd0, AW'(32'h17F), 8'h7E);
      b_load = 1'b0;
      cyc();
      half();
      chk("reload_done",   64'(done_b), 64'd1);
      chk("reload_error",  64'(err_b),  64'd0);
      chk("reload_rf",     64'(full_b), 64'd3);
      chk("reload_a_busy", 64'(busy_a), 64'd0);
      chk("reload_a_done", 64'(done_a), 64'd0);
      rise();

      chk("final_queue_a", 64'(qa.size()), 64'd0);
      chk("final_queue_b", 64'(qb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
